// File: rtl/ddr_pkg.sv
// Shared DDR client constants, reader FSM state type and the 16-bit lane
// byte-swap helper used when DDR_STREAM_BYTESWAP_EN is defined.
package ddr_pkg;
  localparam int DDR_ADDR_W = 29;
  localparam int DDR_DATA_W = 64;
  localparam int DDR_BCNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_ACQUIRE,
    S_REQUEST,
    S_RECEIVE,
    S_FINISH
  } state_t;

  // Swap the two bytes inside every 16-bit lane (big-endian CPU view).
  function automatic logic [DDR_DATA_W-1:0] swap16(input logic [DDR_DATA_W-1:0] d);
    logic [DDR_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DDR_DATA_W/16; i++) begin
      r[16*i +: 8]   = d[16*i+8 +: 8];
      r[16*i+8 +: 8] = d[16*i +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/ddr_if.sv
// DDR client port bundle; to_host is the view of a block issuing reads/writes.
interface ddr_if;
  logic [ddr_pkg::DDR_ADDR_W-1:0] addr;
  logic [ddr_pkg::DDR_DATA_W-1:0] wdata;
  logic                           read;
  logic                           write;
  logic [ddr_pkg::DDR_BCNT_W-1:0] burstcnt;
  logic [7:0]                     byteenable;
  logic                           busy;
  logic                           rdata_ready;
  logic [ddr_pkg::DDR_DATA_W-1:0] rdata;
  logic                           acquire;

  modport to_host (
    output addr, wdata, read, write, burstcnt, byteenable, acquire,
    input  busy, rdata_ready, rdata
  );
endinterface

// File: rtl/ddr_stream_fifo.sv
// First-word-fall-through FIFO. Read data is the head entry whenever not
// empty; a write is accepted while full if a read retires an entry that cycle.
module ddr_stream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full, w_wr, w_rd;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!w_full || w_rd);
  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + AW'(1);
      if (w_rd) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ddr_stream_reader.sv
// Streams a linear region of DDR into a FWFT output FIFO using bursts of at
// most BURST_LEN words. A burst is only requested once the FIFO can absorb it
// completely, so read data never has to be dropped. Only one burst is in
// flight at a time, hence no reservation has to be tracked in WAIT_SPACE.
// Optional macro DDR_STREAM_BYTESWAP_EN swaps bytes in each 16-bit lane of
// out_data (combinational, no added latency).
module ddr_stream_reader
  import ddr_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr_if.to_host                ddr,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] base_addr,
  input  logic [15:0]           length,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DDR_DATA_W-1:0] out_data,
  output logic                  done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state, w_next;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic [DDR_BCNT_W-1:0] r_bcnt, r_beats;
  logic [15:0]           r_remaining;

  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  logic [DDR_DATA_W-1:0] w_fifo_rdata;
  logic [DDR_BCNT_W-1:0] w_burst;
  logic [15:0]           w_free;
  logic                  w_space_ok, w_beat, w_last_beat;

  assign w_burst     = (r_remaining < 16'(BURST_LEN)) ? r_remaining[DDR_BCNT_W-1:0]
                                                      : DDR_BCNT_W'(BURST_LEN);
  assign w_free      = 16'(FIFO_DEPTH) - 16'(w_fifo_count);
  assign w_space_ok  = (w_free >= 16'(w_burst));
  assign w_beat      = (r_state == S_RECEIVE) && ddr.rdata_ready;
  assign w_last_beat = w_beat && (r_beats == r_bcnt - DDR_BCNT_W'(1));

  assign ddr.addr       = r_addr;
  assign ddr.burstcnt   = r_bcnt;
  assign ddr.write      = 1'b0;
  assign ddr.wdata      = '0;
  assign ddr.byteenable = 8'hFF;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = (length == '0) ? S_FINISH : S_WAIT_SPACE;
      S_WAIT_SPACE: if (w_space_ok) w_next = S_ACQUIRE;
      S_ACQUIRE:    w_next = S_REQUEST;
      S_REQUEST:    if (!ddr.busy) w_next = S_RECEIVE;
      S_RECEIVE:    if (w_last_beat)
                      w_next = (r_remaining == 16'(r_bcnt)) ? S_FINISH : S_WAIT_SPACE;
      S_FINISH:     if (w_fifo_empty) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; WAIT_SPACE drops acquire so the arbiter can switch.
  always_comb begin
    ddr.acquire = 1'b0;
    ddr.read    = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_ACQUIRE: ddr.acquire = 1'b1;
      S_REQUEST: begin
        ddr.acquire = 1'b1;
        ddr.read    = 1'b1;
      end
      S_RECEIVE: ddr.acquire = 1'b1;
      S_FINISH:  done = w_fifo_empty;
      default:   ;
    endcase
  end

  // Transfer bookkeeping: address, remaining words, burst size, beat count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_bcnt      <= '0;
      r_beats     <= '0;
      r_remaining <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr      <= base_addr;
        r_remaining <= length;
        r_beats     <= '0;
      end
      if (r_state == S_WAIT_SPACE && w_space_ok) r_bcnt <= w_burst;
      if (w_beat) begin
        if (w_last_beat) begin
          r_beats     <= '0;
          r_addr      <= r_addr + DDR_ADDR_W'(r_bcnt);
          r_remaining <= r_remaining - 16'(r_bcnt);
        end else begin
          r_beats <= r_beats + DDR_BCNT_W'(1);
        end
      end
    end
  end

  ddr_stream_fifo #(
    .WIDTH (DDR_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_beat),
    .i_wr_data (ddr.rdata),
    .i_rd_en   (out_ready),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;

`ifdef DDR_STREAM_BYTESWAP_EN
  assign out_data = swap16(w_fifo_rdata);
`else
  assign out_data = w_fifo_rdata;
`endif
endmodule

// File: tb/tb_ddr_stream_reader.sv
// Directed bench for ddr_stream_reader: DDR model with a 2-cycle busy before
// each accepted read, burst log, output word log and done counter.
module tb_ddr_stream_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [28:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        out_valid, done;
  logic [63:0] out_data;

  ddr_if ddr_bus();

  ddr_stream_reader #(.BURST_LEN(8), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ddr       (ddr_bus),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mword(input logic [28:0] a);
    return 64'h0011223344556677 ^ {35'd0, a};
  endfunction

  function automatic logic [63:0] exp_out(input logic [28:0] a);
    logic [63:0] d, r;
    d = mword(a);
`ifdef DDR_STREAM_BYTESWAP_EN
    for (int i = 0; i < 4; i++) begin
      r[16*i +: 8]   = d[16*i+8 +: 8];
      r[16*i+8 +: 8] = d[16*i +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // DDR model and burst log (only driver of the DDR input signals).
  int          m_phase = 0, m_busy = 0, m_left = 0;
  logic [28:0] m_addr = '0;
  logic [28:0] b_addr [64];
  logic [7:0]  b_cnt  [64];
  int          b_n = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0; m_busy = 0; m_left = 0;
      ddr_bus.busy = 1'b1; ddr_bus.rdata_ready = 1'b0; ddr_bus.rdata = '0;
    end else if (m_phase == 0) begin
      ddr_bus.rdata_ready = 1'b0;
      if (ddr_bus.read && ddr_bus.acquire) begin
        if (m_busy < 2) begin
          ddr_bus.busy = 1'b1; m_busy++;
        end else begin
          ddr_bus.busy = 1'b0; m_busy = 0;
          if (b_n < 64) begin
            b_addr[b_n] = ddr_bus.addr;
            b_cnt[b_n]  = ddr_bus.burstcnt;
          end
          b_n++;
          m_addr = ddr_bus.addr; m_left = int'(ddr_bus.burstcnt); m_phase = 1;
        end
      end else begin
        ddr_bus.busy = 1'b1;
      end
    end else begin
      ddr_bus.busy = 1'b1;
      if (m_left > 0) begin
        ddr_bus.rdata_ready = 1'b1;
        ddr_bus.rdata = mword(m_addr);
        m_addr = m_addr + 29'd1;
        m_left--;
      end else begin
        ddr_bus.rdata_ready = 1'b0;
        m_phase = 0;
      end
    end
  end

  // Output monitor: accepted words, done pulses, acquire rises, read cycles.
  logic [63:0] g_data [256];
  int          g_n = 0, done_cnt = 0, acq_rise = 0, rd_cyc = 0;
  logic        prev_acq = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (g_n < 256) g_data[g_n] = out_data;
        g_n++;
      end
      if (done) done_cnt++;
      if (ddr_bus.acquire && !prev_acq) acq_rise++;
      if (ddr_bus.read) rd_cyc++;
    end
    prev_acq = ddr_bus.acquire;
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic start_xfer(input logic [28:0] b, input logic [15:0] l);
    cyc();
    start = 1'b1; base_addr = b; length = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n, d0;
    n = 0; d0 = done_cnt;
    while (done_cnt == d0 && n < max) begin
      @(negedge clk); n++;
    end
    chk(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic chk_words(input string tag, input int g0, input logic [28:0] b, input int n);
    chk({tag, "_nwords"}, 64'(g_n - g0), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), g_data[(g0 + i) % 256], exp_out(b + 29'(i)));
  endtask

  int b0, g0, d0, a0, r0, n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read",  64'(ddr_bus.read), 64'd0);
    chk("rst_acq",   64'(ddr_bus.acquire), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_write", 64'(ddr_bus.write), 64'd0);
    chk("rst_be",    64'(ddr_bus.byteenable), 64'hFF);
    chk("rst_wdata", ddr_bus.wdata, 64'd0);
    cyc(); reset = 1'b0;

    // Single 8-word burst
    b0 = b_n; g0 = g_n; d0 = done_cnt;
    start_xfer(29'h100, 16'd8);
    wait_done("t1_done", 300);
    repeat (5) @(negedge clk);
    chk("t1_nburst", 64'(b_n - b0), 64'd1);
    chk("t1_addr",   64'(b_addr[b0]), 64'h100);
    chk("t1_bcnt",   64'(b_cnt[b0]), 64'd8);
    chk("t1_done1",  64'(done_cnt - d0), 64'd1);
    chk_words("t1", g0, 29'h100, 8);

    // 20 words -> 8/8/4, with an ignored start mid-transfer
    b0 = b_n; g0 = g_n; d0 = done_cnt; a0 = acq_rise;
    start_xfer(29'h100, 16'd20);
    repeat (15) @(negedge clk);
    start_xfer(29'h900, 16'd5);
    wait_done("t2_done", 400);
    repeat (5) @(negedge clk);
    chk("t2_nburst", 64'(b_n - b0), 64'd3);
    chk("t2_addr0", 64'(b_addr[b0]),   64'h100);
    chk("t2_addr1", 64'(b_addr[b0+1]), 64'h108);
    chk("t2_addr2", 64'(b_addr[b0+2]), 64'h110);
    chk("t2_bcnt0", 64'(b_cnt[b0]),   64'd8);
    chk("t2_bcnt1", 64'(b_cnt[b0+1]), 64'd8);
    chk("t2_bcnt2", 64'(b_cnt[b0+2]), 64'd4);
    chk("t2_acqgap", 64'(acq_rise - a0), 64'd3);
    chk("t2_done1",  64'(done_cnt - d0), 64'd1);
    chk_words("t2", g0, 29'h100, 20);

    // Zero length
    b0 = b_n; r0 = rd_cyc;
    start_xfer(29'h500, 16'd0);
    wait_done("t3_done3", 3);
    repeat (5) @(negedge clk);
    chk("t3_noread", 64'(rd_cyc - r0), 64'd0);
    chk("t3_nburst", 64'(b_n - b0), 64'd0);

    // Back-pressure: FIFO fills after two bursts
    b0 = b_n; g0 = g_n;
    cyc(); out_ready = 1'b0;
    start_xfer(29'h200, 16'd32);
    repeat (150) @(negedge clk);
    chk("t4_stall_nburst", 64'(b_n - b0), 64'd2);
    chk("t4_stall_acq",    64'(ddr_bus.acquire), 64'd0);
    chk("t4_stall_read",   64'(ddr_bus.read), 64'd0);
    chk("t4_stall_valid",  64'(out_valid), 64'd1);
    chk("t4_stall_nout",   64'(g_n - g0), 64'd0);
    cyc(); out_ready = 1'b1;
    wait_done("t4_done", 600);
    chk("t4_nburst", 64'(b_n - b0), 64'd4);
    chk("t4_addr3",  64'(b_addr[b0+3]), 64'h218);
    chk_words("t4", g0, 29'h200, 32);

    // Address wrap, plus the lane byte-swap check on the word from address 0
    b0 = b_n; g0 = g_n;
    start_xfer(29'h1FFFFFFC, 16'd16);
    wait_done("t5_done", 400);
    chk("t5_addr0", 64'(b_addr[b0]),   64'h1FFFFFFC);
    chk("t5_addr1", 64'(b_addr[b0+1]), 64'h4);
    chk_words("t5", g0, 29'h1FFFFFFC, 16);
`ifdef DDR_STREAM_BYTESWAP_EN
    chk("t5_bswap", g_data[(g0 + 4) % 256], 64'h1100332255447766);
`else
    chk("t5_bswap", g_data[(g0 + 4) % 256], 64'h0011223344556677);
`endif

    // Reset in the middle of RECEIVE, then a clean transfer
    start_xfer(29'h300, 16'd16);
    n = 0;
    while (!ddr_bus.rdata_ready && n < 100) begin
      @(negedge clk); n++;
    end
    chk("t6_in_recv", 64'(ddr_bus.rdata_ready), 64'd1);
    cyc(); reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_rst_read",  64'(ddr_bus.read), 64'd0);
    chk("t6_rst_acq",   64'(ddr_bus.acquire), 64'd0);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    cyc(); reset = 1'b0;
    b0 = b_n; g0 = g_n; d0 = done_cnt;
    start_xfer(29'h400, 16'd8);
    wait_done("t6_done", 300);
    repeat (5) @(negedge clk);
    chk("t6_nburst", 64'(b_n - b0), 64'd1);
    chk("t6_addr",   64'(b_addr[b0]), 64'h400);
    chk("t6_done1",  64'(done_cnt - d0), 64'd1);
    chk_words("t6", g0, 29'h400, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
